dmem_responder: RTL and testbench
=================================

# dmem_responder

Off-chip data-memory model answering the data cache's line-fill and write-back requests. It is the memory end of the 256-bit cache/memory interface driven by `dcache_top`. It accepts one whole-line read or write per handshake and completes it after a fixed, parameterised latency with a single-cycle acknowledge. The block is used at testbench top level and in system simulation, wired directly to the CPU's `mem_*` ports.

## Interface

Parameters:

- `LATENCY`, default 10: cycles from request acceptance to `ack_o`; legal range 1–255.
- `DEPTH`, default 512: number of 256-bit lines, giving a 16 KiB default; must be a power of two.

Ports:

- `clk_i` input 1: clock, rising edge.
- `rst_i` input 1: reset, asynchronous, active-high.
- `enable_i` input 1: request valid, from the cache's `mem_enable_o`.
- `write_i` input 1: 1 = line write, 0 = line read.
- `addr_i` input 32: byte address. Bits [4:0] are ignored; the line index is [4+log2(DEPTH):5].
- `data_i` input 256: write line data.
- `ack_o` output 1: completion strobe, exactly one cycle per request.
- `data_o` output 256: read line data, valid while `ack_o`=1.

## Operation

FSM states are IDLE, WAIT and ACK.

- **IDLE**
  - `enable_i`=1 at a rising edge accepts the request.
  - `addr_i`, `write_i` and `data_i` are latched, `cnt` is set to 0, and the FSM goes to WAIT.
  - If LATENCY=1, the FSM goes directly to ACK.
- **WAIT**
  - `cnt` increments each cycle.
  - When `cnt` = LATENCY-2, the next state is ACK.
  - Inputs are ignored. Deassertion of `enable_i` does not cancel a request; it always completes.
- **ACK**
  - `ack_o`=1 for this one cycle.
  - Read: `data_o` = stored line at the latched index.
  - Write: the latched `data_i` is committed to the array at the rising edge that ends the ACK cycle.
  - The next state is always IDLE. This guarantees at least one IDLE cycle between requests, so an `enable_i` still high in the cycle after ack does not retrigger.
- **Out-of-range address** (line index ≥ DEPTH, i.e. `addr_i` ≥ DEPTH*32):
  - Read returns all-zero.
  - Write is dropped.
  - `ack_o` is still issued with normal latency.
- **`data_o` holding**: `data_o` holds the last read value between acks. Writes never change `data_o`.
- **Array contents**: the array is not cleared by reset. Initial content is all-zero at time 0, optionally overridden by a hex-file load in simulation.

## Timing

- Reset values:
  - `ack_o`=0.
  - `data_o`=0.
  - State IDLE.
  - `cnt`=0.
  - Latched request fields = 0.
- Both outputs are registered; there is no combinational path from inputs to outputs.
- Latency: with acceptance at edge E, `ack_o` is high in the cycle following edge E+LATENCY-1, i.e. LATENCY cycles after acceptance.
- Throughput: one request per LATENCY+1 cycles at most.
- Reset asserted mid-WAIT or mid-ACK:
  - The request is aborted and no ack is issued.
  - A pending write is not committed.
  - The array keeps its prior contents.
- A write followed by a read of the same line returns the written data. The commit precedes the earliest possible next acceptance by at least one edge.
- `cnt` width is 8 bits; it never wraps within a legal LATENCY.

## Structure

- Package `dmem_pkg`:
  - `LINE_W`=256, `ADDR_W`=32, `OFFSET_W`=5.
  - State enum `dmem_state_t` {IDLE, WAIT, ACK}.
- Sub-module `dmem_array`:
  - Single-port, synchronous-write, asynchronous-read line RAM with parameter DEPTH.
  - Ports: clock, write enable, index, write data, read data.
- The top level holds the FSM, counter, request latch, range check and output registers.

## Test plan

- **Reset then read**: reset, then read of `addr_i`=0x0000_0040 with LATENCY=10 → `ack_o` rises exactly 10 cycles after acceptance, for 1 cycle, with `data_o`=0.
- **Write/read-back**: write 256'hA5…A5 to 0x0000_0120, then read 0x0000_013F (same line, different offset) → read ack returns 256'hA5…A5.
- **Held enable**: hold `enable_i` high continuously across one read → exactly one ack, and a second request is accepted only on the edge after the mandatory IDLE cycle.
- **Out of range**: write 256'h1 to address DEPTH*32 → ack is issued; a read of line 0 still returns its old value; a read of the out-of-range address returns 0.
- **Reset mid-write**: assert `rst_i` 4 cycles into a write to 0x0000_0200 → no ack, outputs 0, and a later read of 0x0000_0200 returns the pre-write value.
- **LATENCY=1 corner**: with LATENCY=1, back-to-back write then read → acks arrive 2 cycles apart and the read data equals the write data.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared widths and FSM state encoding for the 256-bit data-memory model.
package dmem_pkg;

    localparam int LINE_W   = 256;
    localparam int ADDR_W   = 32;
    localparam int OFFSET_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// Line RAM with one shared index: synchronous write, asynchronous read.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [LINE_W-1:0] wdata,
    output logic [LINE_W-1:0] rdata
);

    logic [LINE_W-1:0] mem [DEPTH];

    // NOTE: the storage has no reset; contents must survive a reset pulse.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Memory end of the 256-bit cache/memory interface: one whole-line read or
// write per handshake, acknowledged after a fixed LATENCY with a 1-cycle strobe.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int LATENCY = 10,
    parameter int DEPTH   = 512
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              write_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LINE_W-1:0] data_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o
);

    localparam int         IDX_W    = $clog2(DEPTH);
    localparam int         LINE_AW  = ADDR_W - OFFSET_W;
    localparam logic [7:0] LAST_CNT = 8'(LATENCY - 2);

    dmem_state_t        state;
    dmem_state_t        next_state;
    logic [7:0]         cnt;
    logic               req_write;
    logic [LINE_AW-1:0] req_line;
    logic [LINE_W-1:0]  req_data;

    logic [LINE_AW-1:0] cur_line;
    logic               cur_write;
    logic               in_range;
    logic               arr_we;
    logic [LINE_W-1:0]  rd_data;
    logic               unused_offset;

    assign unused_offset = ^addr_i[OFFSET_W-1:0];

    // In IDLE the live address drives the array so LATENCY=1 can read on acceptance.
    assign cur_line  = (state == IDLE) ? addr_i[ADDR_W-1:OFFSET_W] : req_line;
    assign cur_write = (state == IDLE) ? write_i : req_write;
    assign in_range  = (cur_line >> IDX_W) == '0;
    assign arr_we    = (state == ACK) && req_write && in_range;

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk_i),
        .we    (arr_we),
        .idx   (cur_line[IDX_W-1:0]),
        .wdata (req_data),
        .rdata (rd_data)
    );

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (enable_i) next_state = (LATENCY == 1) ? ACK : WAIT;
            WAIT: if (cnt == LAST_CNT) next_state = ACK;
            ACK:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all update on the same edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            cnt       <= '0;
            req_write <= 1'b0;
            req_line  <= '0;
            req_data  <= '0;
            ack_o     <= 1'b0;
            data_o    <= '0;
        end else begin
            state <= next_state;
            ack_o <= (next_state == ACK);

            case (state)
                IDLE: begin
                    if (enable_i) begin
                        req_write <= write_i;
                        req_line  <= addr_i[ADDR_W-1:OFFSET_W];
                        req_data  <= data_i;
                        cnt       <= '0;
                    end
                end
                WAIT:    cnt <= cnt + 8'd1;
                default: ;
            endcase

            // Read data is captured on the edge entering ACK; writes leave data_o alone.
            if (next_state == ACK && !cur_write) begin
                data_o <= in_range ? rd_data : '0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: a LATENCY=10 instance driven from a vector table plus hand
// sequences, and a LATENCY=1 instance for the back-to-back corner.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int LAT_A = 10;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [255:0] data;
        logic [255:0] exp;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         a_en = 1'b0, a_wr = 1'b0;
    logic [31:0]  a_addr = '0;
    logic [255:0] a_data = '0;
    logic         a_ack;
    logic [255:0] a_dout;
    logic         b_en = 1'b0, b_wr = 1'b0;
    logic [31:0]  b_addr = '0;
    logic [255:0] b_data = '0;
    logic         b_ack;
    logic [255:0] b_dout;

    int           errors = 0;
    int           checks = 0;
    logic [255:0] last_rd = '0;
    vec_t         vecs[11];

    always #5 clk = ~clk;

    dmem_responder #(.LATENCY(LAT_A), .DEPTH(512)) dut_a (
        .clk_i(clk), .rst_i(rst), .enable_i(a_en), .write_i(a_wr),
        .addr_i(a_addr), .data_i(a_data), .ack_o(a_ack), .data_o(a_dout)
    );

    dmem_responder #(.LATENCY(1), .DEPTH(512)) dut_b (
        .clk_i(clk), .rst_i(rst), .enable_i(b_en), .write_i(b_wr),
        .addr_i(b_addr), .data_i(b_data), .ack_o(b_ack), .data_o(b_dout)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_req(input vec_t v, input string name);
        int n;
        @(negedge clk);
        a_en = 1'b1; a_wr = v.wr; a_addr = v.addr; a_data = v.data;
        @(posedge clk);
        @(negedge clk);
        a_en = 1'b0;
        n = 1;
        while (a_ack !== 1'b1 && n < LAT_A + 5) begin
            @(negedge clk);
            n++;
        end
        check({name, "_lat"}, 256'(n), 256'(LAT_A));
        if (v.wr) begin
            check({name, "_hold"}, a_dout, last_rd);
        end else begin
            check({name, "_data"}, a_dout, v.exp);
            last_rd = v.exp;
        end
        @(negedge clk);
        check({name, "_pulse"}, 256'(a_ack), 256'd0);
    endtask

    task automatic held_enable();
        int first  = -1;
        int second = -1;
        @(negedge clk);
        a_en = 1'b1; a_wr = 1'b0; a_addr = 32'h0000_013F;
        for (int c = 1; c <= 2 * LAT_A + 4 && second < 0; c++) begin
            @(negedge clk);
            if (a_ack === 1'b1) begin
                check("held_data", a_dout, {32{8'hA5}});
                if (first < 0) first = c;
                else           second = c;
            end
        end
        a_en = 1'b0;
        check("held_first", 256'(first), 256'(LAT_A));
        check("held_second", 256'(second), 256'(2 * LAT_A + 1));
        @(negedge clk);
        check("held_pulse", 256'(a_ack), 256'd0);
        last_rd = {32{8'hA5}};
    endtask

    task automatic reset_mid_write();
        int acks = 0;
        @(negedge clk);
        a_en = 1'b1; a_wr = 1'b1; a_addr = 32'h0000_0200; a_data = {32{8'h3C}};
        @(posedge clk);
        @(negedge clk);
        a_en = 1'b0;
        if (a_ack === 1'b1) acks++;
        repeat (3) begin
            @(negedge clk);
            if (a_ack === 1'b1) acks++;
        end
        rst = 1'b1;
        #1;
        check("rstw_ack", 256'(a_ack), 256'd0);
        check("rstw_data", a_dout, 256'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (LAT_A + 3) begin
            @(negedge clk);
            if (a_ack === 1'b1) acks++;
        end
        check("rstw_no_ack", 256'(acks), 256'd0);
        last_rd = '0;
    endtask

    task automatic latency_one();
        @(negedge clk);
        b_en = 1'b1; b_wr = 1'b1; b_addr = 32'h0000_0060; b_data = {8{32'hC0FF_EE11}};
        @(negedge clk);
        check("l1_wr_ack", 256'(b_ack), 256'd1);
        check("l1_wr_hold", b_dout, 256'd0);
        b_wr = 1'b0;
        @(negedge clk);
        check("l1_idle", 256'(b_ack), 256'd0);
        @(negedge clk);
        check("l1_rd_ack", 256'(b_ack), 256'd1);
        check("l1_rd_data", b_dout, {8{32'hC0FF_EE11}});
        b_en = 1'b0;
        @(negedge clk);
        check("l1_pulse", 256'(b_ack), 256'd0);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 32'h0000_0040, '0,                 '0};
        vecs[1]  = '{1'b1, 32'h0000_0120, {32{8'hA5}},        '0};
        vecs[2]  = '{1'b0, 32'h0000_013F, '0,                 {32{8'hA5}}};
        vecs[3]  = '{1'b1, 32'h0000_0000, {8{32'hDEAD_BEEF}}, '0};
        vecs[4]  = '{1'b1, 32'h0000_0200, {16{16'h1234}},     '0};
        vecs[5]  = '{1'b1, 32'h0000_4000, 256'd1,             '0};
        vecs[6]  = '{1'b0, 32'h0000_0000, '0,                 {8{32'hDEAD_BEEF}}};
        vecs[7]  = '{1'b0, 32'h0000_4000, '0,                 '0};
        vecs[8]  = '{1'b1, 32'h0000_3FFF, {8{32'h0BAD_F00D}}, '0};
        vecs[9]  = '{1'b0, 32'h0000_3FE0, '0,                 {8{32'h0BAD_F00D}}};
        vecs[10] = '{1'b0, 32'h0000_0120, '0,                 {32{8'hA5}}};

        repeat (3) @(negedge clk);
        check("rst_a_ack", 256'(a_ack), 256'd0);
        check("rst_a_data", a_dout, 256'd0);
        check("rst_b_ack", 256'(b_ack), 256'd0);
        check("rst_b_data", b_dout, 256'd0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            do_req(vecs[i], $sformatf("v%0d", i));
        end

        held_enable();
        reset_mid_write();
        do_req('{1'b0, 32'h0000_0200, '0, {16{16'h1234}}}, "rstw_readback");
        latency_one();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
